k2mul_pipe: RTL and testbench
=============================

K2MUL_PIPE -- requirements
Module: k2mul_pipe

Interface
REQ-001 SHALL have parameter WID, default 24: product width delivered to the downstream K2RED stage.
REQ-002 SHALL have parameter WID2, default 12: operand width (Kyber coefficient).
REQ-003 SHALL have parameter NCOEF, default 256: coefficients per polynomial block.
REQ-004 SHALL have port clk  input  1: single clock, all state on rising edge.
REQ-005 SHALL have port rst  input  1: synchronous, active-high reset.
REQ-006 SHALL have port in_valid  input  1: operand pair offered.
REQ-007 SHALL have port in_ready  output  1: operand pair accepted when in_valid && in_ready.
REQ-008 SHALL have port a  input  WID2: operand A, unsigned.
REQ-009 SHALL have port b  input  WID2: operand B, unsigned.
REQ-010 SHALL have port out_valid  output  1: product c valid.
REQ-011 SHALL have port out_ready  input  1: downstream reducer accepts c.
REQ-012 SHALL have port c  output  WID: unsigned product, input to K2RED.
REQ-013 SHALL have port out_last  output  1: c is the final coefficient of a block.

Function
REQ-014 SHALL be a 2-stage pipeline: S1 registers operands; S2 registers c = a*b (full WID-bit unsigned, no truncation, since (2^12-1)^2 < 2^24).
REQ-015 SHALL have a latency of exactly 2 cycles from acceptance to out_valid when not stalled; throughput SHALL be 1 pair/cycle while out_ready=1.
REQ-016 SHALL advance S2 when !s2_valid || out_ready; S1 SHALL advance when !s1_valid || S2 advancing.
REQ-017 SHALL drive in_ready = !s1_valid || S1 advancing (combinational from out_ready; no skid).
REQ-018 SHALL hold c, out_last and out_valid stable while out_valid && !out_ready.
REQ-019 SHALL hold at most 2 pairs when stalled; in_ready SHALL drop only when both stages are full and out_ready=0.
REQ-020 SHALL count accepted pairs 0..NCOEF-1, wrapping to 0; pair with count NCOEF-1 SHALL carry last=1 through both stages to out_last.
REQ-021 SHALL accept a new pair and retire an old pair in the same cycle without a bubble when full and out_ready=1.
REQ-022 SHALL have no state machine beyond per-stage valid bits and the counter; no data SHALL be dropped or duplicated under any in_valid/out_ready pattern.

Reset
REQ-023 SHALL, on rst=1 at a clock edge, set s1_valid=0, s2_valid=0, counter=0, c=0, out_last=0; out_valid SHALL read 0 the cycle after.
REQ-024 SHALL discard in-flight pairs on reset mid-block; the next accepted pair SHALL be count 0.
REQ-025 SHALL drive in_ready=1 the cycle after reset deasserts.

Configuration
REQ-026 With K2MUL_INRED_EN defined, S1 SHALL replace each operand x >= 3329 by x-3329 before multiplying (one conditional subtract, same stage, latency unchanged).
REQ-027 Without K2MUL_INRED_EN, operands SHALL pass unmodified; the caller SHALL guarantee they are < 3329 if a canonical result is required.

Structure
REQ-028 SHALL import from shared package k2_pkg: KYBER_Q=3329, WID, WID2, NCOEF defaults and counter width clog2(NCOEF).
REQ-029 SHALL implement each stage with one sub-module, k2_pipe_reg (valid/ready register slice, data width parameterised), instantiated twice.

Verification
REQ-030 Single pair a=3328,b=3328, out_ready=1 -> out_valid 2 cycles later, c=11075584, out_last=0.
REQ-031 Stream 3 pairs with out_ready=0 for 5 cycles -> 2 accepted, in_ready=0 on 3rd; after out_ready=1, outputs in order, none lost.
REQ-032 256 back-to-back pairs, out_ready=1 -> 256 outputs on consecutive cycles, out_last=1 only on the 256th; a 257th pair -> out_last=0 (wrap).
REQ-033 K2MUL_INRED_EN defined, a=4000,b=2 -> c=1342; undefined -> c=8000.
REQ-034 rst=1 while out_valid=1 and S1 full -> out_valid=0, in_ready=1 next cycle; next block's 256th output carries out_last.
REQ-035 Random in_valid/out_ready (50%), 1000 random pairs -> scoreboard matches a*b in order, with c stable during every stall.

Source files
------------

// File: rtl/k2_pkg.sv
// Shared constants for the Kyber K2 datapath: modulus, default widths and
// the coefficient-counter width helper.
package k2_pkg;

  localparam int KYBER_Q   = 3329;
  localparam int WID_DEF   = 24;
  localparam int WID2_DEF  = 12;
  localparam int NCOEF_DEF = 256;

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int CNT_W_DEF = cnt_width(NCOEF_DEF);

endpackage

// File: rtl/k2_pipe_reg.sv
// Single valid/ready register slice; accepts when empty or when its content
// is being taken downstream in the same cycle.
module k2_pipe_reg #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data
);

  logic          valid_q, valid_d;
  logic [DW-1:0] data_q, data_d;

  assign in_ready = !valid_q || out_ready;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (in_ready) begin
      valid_d = in_valid;
      if (in_valid) data_d = in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;

endmodule

// File: rtl/k2mul_pipe.sv
// Two-stage Kyber coefficient multiplier feeding K2RED, with block-last tagging.
// Define K2MUL_INRED_EN to fold operands >= KYBER_Q once before multiplying.
module k2mul_pipe
  import k2_pkg::*;
#(
  parameter int WID   = WID_DEF,
  parameter int WID2  = WID2_DEF,
  parameter int NCOEF = NCOEF_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [WID2-1:0] a,
  input  logic [WID2-1:0] b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [WID-1:0]  c,
  output logic            out_last
);

  localparam int             CW       = cnt_width(NCOEF);
  localparam logic [CW-1:0]  LAST_CNT = CW'(NCOEF - 1);
  localparam int             S1W      = 2 * WID2 + 1;
  localparam int             S2W      = WID + 1;

  logic [CW-1:0]   cnt_q, cnt_d;
  logic            accept;
  logic [WID2-1:0] a_red, b_red;
  logic [S1W-1:0]  s1_din, s1_dout;
  logic [S2W-1:0]  s2_din, s2_dout;
  logic            s1_valid, s2_valid, s2_in_ready;
  logic            s1_last;
  logic [WID2-1:0] s1_a, s1_b;
  logic [WID-1:0]  prod;

  assign accept = in_valid && in_ready;

  always_comb begin
    cnt_d = cnt_q;
    if (accept) cnt_d = (cnt_q == LAST_CNT) ? '0 : cnt_q + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

`ifdef K2MUL_INRED_EN
  localparam logic [WID2-1:0] Q_W = WID2'(KYBER_Q);
  assign a_red = (a >= Q_W) ? a - Q_W : a;
  assign b_red = (b >= Q_W) ? b - Q_W : b;
`else
  assign a_red = a;
  assign b_red = b;
`endif

  assign s1_din = {(cnt_q == LAST_CNT), a_red, b_red};

  k2_pipe_reg #(.DW(S1W)) u_s1 (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (s1_din),
    .out_valid(s1_valid),
    .out_ready(s2_in_ready),
    .out_data (s1_dout)
  );

  assign {s1_last, s1_a, s1_b} = s1_dout;
  // Operands are widened first so the full 2*WID2-bit product is kept.
  assign prod   = WID'(s1_a) * WID'(s1_b);
  assign s2_din = {s1_last, prod};

  k2_pipe_reg #(.DW(S2W)) u_s2 (
    .clk      (clk),
    .rst      (rst),
    .in_valid (s1_valid),
    .in_ready (s2_in_ready),
    .in_data  (s2_din),
    .out_valid(s2_valid),
    .out_ready(out_ready),
    .out_data (s2_dout)
  );

  assign out_valid     = s2_valid;
  assign {out_last, c} = s2_dout;

endmodule

// File: tb/tb_k2mul_pipe.sv
// Self-checking bench for k2mul_pipe: directed corner cases plus a random
// valid/ready stream checked against a queue-based product model.
module tb_k2mul_pipe;

  localparam int WID   = 24;
  localparam int WID2  = 12;
  localparam int NCOEF = 256;
  localparam int Q     = 3329;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [WID2-1:0] a = '0;
  logic [WID2-1:0] b = '0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [WID-1:0]  c;
  logic            out_last;

  int n_checks = 0;
  int n_fail   = 0;

  logic [WID:0]   exp_q[$];
  int             mdl_cnt = 0;
  int             n_acc = 0, n_ret = 0, n_last = 0;
  bit             acc_now = 0;
  bit             stall_prev = 0;
  logic [WID-1:0] stall_c;
  logic           stall_last;

  k2mul_pipe #(.WID(WID), .WID2(WID2), .NCOEF(NCOEF)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .c        (c),
    .out_last (out_last)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, obs, expv);
    end
  endtask

  function automatic int reduce(input int x);
`ifdef K2MUL_INRED_EN
    return (x >= Q) ? x - Q : x;
`else
    return x;
`endif
  endfunction

  // One clock: drive at the falling edge, observe the handshake mid low-phase.
  task automatic applyStimulus(input bit r, input bit v, input int av, input int bv, input bit ordy);
    logic [WID:0] e;
    @(negedge clk);
    rst       = r;
    in_valid  = v;
    a         = av[WID2-1:0];
    b         = bv[WID2-1:0];
    out_ready = ordy;
    #1;
    if (r) begin
      exp_q.delete();
      mdl_cnt    = 0;
      stall_prev = 0;
      acc_now    = 0;
    end else begin
      if (stall_prev) begin
        checkOutput("stall_valid", 64'(out_valid), 64'd1);
        checkOutput("stall_c", 64'(c), 64'(stall_c));
        checkOutput("stall_last", 64'(out_last), 64'(stall_last));
      end
      acc_now = in_valid && in_ready;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checkOutput("sb_underflow", 64'd1, 64'd0);
        end else begin
          e = exp_q.pop_front();
          checkOutput("sb_c", 64'(c), 64'(e[WID-1:0]));
          checkOutput("sb_last", 64'(out_last), 64'(e[WID]));
        end
        n_ret++;
        if (out_last) n_last++;
      end
      if (acc_now) begin
        exp_q.push_back({(mdl_cnt == NCOEF - 1), WID'(reduce(av) * reduce(bv))});
        mdl_cnt = (mdl_cnt + 1) % NCOEF;
        n_acc++;
      end
      stall_prev = out_valid && !out_ready;
      stall_c    = c;
      stall_last = out_last;
    end
  endtask

  initial begin
    int sent, ir3, acc0, ret0, last0, guard;
    int pa[3];
    int pb[3];

    applyStimulus(1, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
    checkOutput("rst_c", 64'(c), 64'd0);
    checkOutput("rst_out_last", 64'(out_last), 64'd0);
    checkOutput("rst_in_ready", 64'(in_ready), 64'd1);

    // Single max-canonical pair and its 2-cycle latency
    applyStimulus(0, 1, 3328, 3328, 1);
    checkOutput("single_accept", 64'(acc_now), 64'd1);
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("lat1_out_valid", 64'(out_valid), 64'd0);
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("lat2_out_valid", 64'(out_valid), 64'd1);
    checkOutput("single_c", 64'(c), 64'd11075584);
    checkOutput("single_last", 64'(out_last), 64'd0);

    // Non-canonical operand
    applyStimulus(0, 1, 4000, 2, 1);
    applyStimulus(0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("inred_valid", 64'(out_valid), 64'd1);
`ifdef K2MUL_INRED_EN
    checkOutput("inred_c", 64'(c), 64'd1342);
`else
    checkOutput("inred_c", 64'(c), 64'd8000);
`endif

    // Three pairs against a 5-cycle stall
    pa = '{11, 222, 3000};
    pb = '{7, 3001, 4095};
    sent = 0; ir3 = -1; ret0 = n_ret;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(0, (sent < 3), pa[sent % 3], pb[sent % 3], 0);
      if (i == 2) ir3 = int'(in_ready);
      if (acc_now) sent++;
    end
    checkOutput("stall_accepted", 64'(sent), 64'd2);
    checkOutput("stall_in_ready3", 64'(ir3), 64'd0);
    guard = 0;
    while (sent < 3 && guard < 20) begin
      applyStimulus(0, 1, pa[2], pb[2], 1);
      if (acc_now) sent++;
      guard++;
    end
    for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 0, 1);
    checkOutput("stall_retired", 64'(n_ret - ret0), 64'd3);

    // Full block back-to-back plus one wrapping pair
    applyStimulus(1, 0, 0, 0, 1);
    acc0 = n_acc; ret0 = n_ret; last0 = n_last;
    for (int i = 0; i < NCOEF + 1; i++)
      applyStimulus(0, 1, int'($urandom_range(0, Q - 1)), int'($urandom_range(0, Q - 1)), 1);
    for (int i = 0; i < 2; i++) applyStimulus(0, 0, 0, 0, 1);
    checkOutput("b2b_accepted", 64'(n_acc - acc0), 64'(NCOEF + 1));
    checkOutput("b2b_retired", 64'(n_ret - ret0), 64'(NCOEF + 1));
    checkOutput("b2b_last_count", 64'(n_last - last0), 64'd1);

    // Reset with both stages full, then a fresh block
    applyStimulus(0, 1, 5, 6, 0);
    applyStimulus(0, 1, 7, 8, 0);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("full_out_valid", 64'(out_valid), 64'd1);
    checkOutput("full_in_ready", 64'(in_ready), 64'd0);
    applyStimulus(1, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("midrst_out_valid", 64'(out_valid), 64'd0);
    checkOutput("midrst_in_ready", 64'(in_ready), 64'd1);
    acc0 = n_acc; last0 = n_last;
    for (int i = 0; i < NCOEF; i++)
      applyStimulus(0, 1, int'($urandom_range(0, 4095)), int'($urandom_range(0, 4095)), 1);
    for (int i = 0; i < 2; i++) applyStimulus(0, 0, 0, 0, 1);
    checkOutput("blk2_accepted", 64'(n_acc - acc0), 64'(NCOEF));
    checkOutput("blk2_last_count", 64'(n_last - last0), 64'd1);

    // Random valid/ready traffic
    acc0 = n_acc; guard = 0;
    while ((n_acc - acc0) < 1000 && guard < 20000) begin
      applyStimulus(0, bit'($urandom_range(0, 1)), int'($urandom_range(0, 4095)),
                    int'($urandom_range(0, 4095)), bit'($urandom_range(0, 1)));
      guard++;
    end
    checkOutput("rand_accepted", 64'(n_acc - acc0), 64'd1000);
    guard = 0;
    while (exp_q.size() != 0 && guard < 50) begin
      applyStimulus(0, 0, 0, 0, 1);
      guard++;
    end
    checkOutput("rand_drained", 64'(exp_q.size()), 64'd0);
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("idle_out_valid", 64'(out_valid), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
